riscv_test_monitor: RTL and testbench

Synthesizable end-of-test monitor for the open RISC-V core. It snoops the register-file write-back port and tracks the test-number, done and result registers used by the rv32ui test programs. After a settle window it declares pass, fail or timeout, so pass/fail detection needs no hierarchical peeking and works in simulation, on FPGA and with multi-test regressions. It sits beside the core inside the SoC, wired to the write-back signals of the register file.

---
 rtl/riscv_test_monitor_pkg.sv | 21 ++
 rtl/riscv_test_monitor_shadow.sv | 34 +++
 rtl/riscv_test_monitor.sv | 150 +++++++++++++++
 tb/tb_riscv_test_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_monitor_pkg: shared types and constants
// for the end-of-test monitor.
package riscv_test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam int DEF_TESTNUM_REG = 3;
  localparam int DEF_DONE_REG    = 26;
  localparam int DEF_RESULT_REG  = 27;

  localparam int RESULT_PASS_VAL = 1;
  localparam int DONE_VAL        = 1;

endpackage

// File: rtl/riscv_test_monitor_shadow.sv
// riscv_test_monitor_shadow: snooped copy of the
// register file for post-mortem dumps.
module riscv_test_monitor_shadow #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [XLEN-1:0]   rdata
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [XLEN-1:0] mem [DEPTH];

  // capture snooped writes; x0 is never stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (clr) begin
      mem <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: pass/fail/timeout detection from write-back snooping.
// Define RISCV_TEST_MONITOR_DUMP_EN to add the readable shadow register file.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          REG_AW         = 5,
  parameter int          TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int          DONE_REG       = DEF_DONE_REG,
  parameter int          RESULT_REG     = DEF_RESULT_REG,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-1:0]   fail_testnum,
  output logic [CNT_W-1:0]  cycle_count,
  input  logic [REG_AW-1:0] dump_addr,
  output logic [XLEN-1:0]   dump_data
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST  =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      SET_LAST = 16'(SETTLE_CYCLES);

  state_t          state;
  logic [XLEN-1:0] tn_q;
  logic [XLEN-1:0] res_q;
  logic [15:0]     scnt;

  logic qual;
  logic snoop;
  logic tn_wr;
  logic res_wr;
  logic done_wr;
  logic to_hit;

  assign qual    = wb_we && (wb_addr != '0);
  assign snoop   = (state == ST_RUN) || (state == ST_SETTLE);
  assign tn_wr   = qual && (wb_addr == REG_AW'(TESTNUM_REG));
  assign res_wr  = qual && (wb_addr == REG_AW'(RESULT_REG));
  assign done_wr = qual && (wb_addr == REG_AW'(DONE_REG))
                   && (wb_data == XLEN'(DONE_VAL));
  assign to_hit  = (TIMEOUT_CYCLES != 0)
                   && (cycle_count == TO_LAST);

  // verdict FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tn_q         <= '0;
      res_q        <= '0;
      scnt         <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
      cycle_count  <= '0;
    end else if (!en) begin
      state        <= ST_IDLE;
      tn_q         <= '0;
      res_q        <= '0;
      scnt         <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
      cycle_count  <= '0;
    end else begin
      if (snoop && tn_wr) tn_q <= wb_data;
      if (snoop && res_wr) res_q <= wb_data;
      if (snoop && (cycle_count != CNT_MAX))
        cycle_count <= cycle_count + CNT_W'(1);
      unique case (state)
        ST_IDLE: begin
          state       <= ST_RUN;
          cycle_count <= '0;
          scnt        <= '0;
          tn_q        <= '0;
          res_q       <= '0;
        end
        ST_RUN: begin
          if (done_wr) begin
            state <= ST_SETTLE;
            scnt  <= '0;
          end else if (to_hit) begin
            state        <= ST_TIMEOUT;
            done         <= 1'b1;
            fail         <= 1'b1;
            timeout      <= 1'b1;
            fail_testnum <= tn_q;
          end
        end
        ST_SETTLE: begin
          if (scnt == SET_LAST) begin
            done         <= 1'b1;
            fail_testnum <= tn_q;
            if (res_q == XLEN'(RESULT_PASS_VAL)) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end else begin
            scnt <= scnt + 16'd1;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RISCV_TEST_MONITOR_DUMP_EN
  logic sh_clr;
  assign sh_clr = (state == ST_IDLE) || !en;

  riscv_test_monitor_shadow #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .we    (snoop && qual),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (dump_addr),
    .rdata (dump_data)
  );
`else
  logic unused_dump;
  assign unused_dump = ^dump_addr;
  assign dump_data   = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed and random checks
// against a behavioural model of the monitor.
module tb_riscv_test_monitor;

  localparam int S = 10;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  dump_addr = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_testnum, cycle_count, dump_data;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data)
  );

  int nerr = 0;
  int nchk = 0;

  // model: verdict 0 none, 1 pass, 2 fail, 3 timeout
  int          m_v;
  bit          m_idle, m_run, m_set;
  logic [31:0] m_tn, m_res, m_ftn, m_cyc;
  logic [31:0] m_regs [32];
  longint      m_edge = 0;
  longint      m_done_at = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_idle = 1; m_run = 0; m_set = 0;
    m_tn = 0; m_res = 0; m_ftn = 0; m_cyc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic model_step();
    logic        q;
    logic [31:0] o_tn, o_res, o_cyc;
    m_edge++;
    if (rst || !en) begin
      model_reset();
      return;
    end
    if (m_idle) begin
      model_reset();
      m_idle = 0;
      m_run = 1;
      return;
    end
    if (m_v != 0) return;
    q = wb_we && (wb_addr != 0);
    o_tn = m_tn; o_res = m_res; o_cyc = m_cyc;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    if (m_run) begin
      if (q && wb_addr == 26 && wb_data == 1) begin
        m_run = 0; m_set = 1; m_done_at = m_edge;
      end else if (T != 0 && o_cyc == T - 1) begin
        m_run = 0; m_v = 3; m_ftn = o_tn;
      end
    end else if (m_edge - m_done_at == S + 1) begin
      m_set = 0;
      m_v = (o_res == 1) ? 1 : 2;
      m_ftn = o_tn;
    end
    if (q) begin
      if (wb_addr == 3) m_tn = wb_data;
      if (wb_addr == 27) m_res = wb_data;
      m_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_dump;
`ifdef RISCV_TEST_MONITOR_DUMP_EN
    exp_dump = (dump_addr == 0) ? 0 : m_regs[dump_addr];
`else
    exp_dump = 0;
`endif
    chk("done", 32'(done), 32'(m_v != 0));
    chk("pass", 32'(pass), 32'(m_v == 1));
    chk("fail", 32'(fail), 32'(m_v >= 2));
    chk("timeout", 32'(timeout), 32'(m_v == 3));
    chk("fail_testnum", fail_testnum, m_ftn);
    chk("cycle_count", cycle_count, m_cyc);
    chk("dump_data", dump_data, exp_dump);
  endtask

  // per-edge model update and comparison
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1 compare_all();
    end
  end

  task automatic idle_cyc();
    wb_we = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    wb_we = 1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_we = 0;
  endtask

  task automatic restart();
    en = 0;
    idle_cyc();
    en = 1;
    idle_cyc();
  endtask

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_ftn", fail_testnum, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_dump", dump_data, 0);
    @(negedge clk);
    rst = 0;

    // pass path
    restart();
    wr(3, 5); wr(27, 1); wr(26, 1);
    repeat (S) idle_cyc();
    chk("pass_early", 32'(pass), 0);
    idle_cyc();
    chk("pass_pass", 32'(pass), 1);
    chk("pass_done", 32'(done), 1);
    chk("pass_fail", 32'(fail), 0);
    chk("pass_ftn", fail_testnum, 5);

    // en dropped in PASS
    en = 0;
    idle_cyc();
    chk("en_drop_done", 32'(done), 0);
    chk("en_drop_pass", 32'(pass), 0);
    chk("en_drop_cnt", cycle_count, 0);

    // late result overrides
    restart();
    wr(3, 7); wr(27, 1); wr(26, 1);
    repeat (7) idle_cyc();
    wr(27, 0);
    repeat (4) idle_cyc();
    chk("late_fail", 32'(fail), 1);
    chk("late_pass", 32'(pass), 0);
    chk("late_ftn", fail_testnum, 7);

    // result at last included edge
    restart();
    wr(27, 0); wr(26, 1);
    repeat (9) idle_cyc();
    wr(27, 1);
    idle_cyc();
    chk("edge_in_pass", 32'(pass), 1);

    // result one edge too late
    restart();
    wr(27, 0); wr(26, 1);
    repeat (10) idle_cyc();
    wr(27, 1);
    chk("edge_out_fail", 32'(fail), 1);
    chk("edge_out_pass", 32'(pass), 0);

    // timeout
    restart();
    repeat (T - 1) idle_cyc();
    chk("to_before", 32'(timeout), 0);
    chk("to_cnt_before", cycle_count, T - 1);
    idle_cyc();
    chk("to_timeout", 32'(timeout), 1);
    chk("to_fail", 32'(fail), 1);
    chk("to_done", 32'(done), 1);
    chk("to_cnt", cycle_count, T);
    repeat (5) idle_cyc();
    chk("to_cnt_frozen", cycle_count, T);

    // ignored writes
    restart();
    wr(0, 1); wr(26, 2); wr(3, 9);
    repeat (S + 2) idle_cyc();
    chk("ign_done", 32'(done), 0);
    wr(27, 1); wr(26, 1);
    repeat (S + 1) idle_cyc();
    chk("ign_pass", 32'(pass), 1);
    chk("ign_ftn", fail_testnum, 9);

    // collision: done write on timeout edge
    restart();
    repeat (T - 1) idle_cyc();
    wr(26, 1);
    chk("col_no_to", 32'(timeout), 0);
    repeat (S + 1) idle_cyc();
    chk("col_done", 32'(done), 1);
    chk("col_fail", 32'(fail), 1);
    chk("col_timeout", 32'(timeout), 0);

    // reset mid-settle
    restart();
    wr(27, 1); wr(26, 1);
    repeat (3) idle_cyc();
    #1 rst = 1;
    #1;
    chk("arst_cnt", cycle_count, 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pass", 32'(pass), 0);
    model_reset();
    #1 rst = 0;
    @(negedge clk);

    // dump readout
    restart();
    wr(10, 32'hDEAD_BEEF);
    dump_addr = 10;
    #1;
`ifdef RISCV_TEST_MONITOR_DUMP_EN
    chk("dump_x10", dump_data, 32'hDEAD_BEEF);
`else
    chk("dump_off", dump_data, 0);
`endif
    dump_addr = 0;
    #1 chk("dump_x0", dump_data, 0);
    @(negedge clk);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      restart();
      for (int i = 0; i < $urandom_range(20, 90); i++) begin
        case ($urandom_range(0, 5))
          0: wb_addr = 0;
          1: wb_addr = 3;
          2: wb_addr = 26;
          3: wb_addr = 27;
          default: wb_addr = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: wb_data = 0;
          1: wb_data = 1;
          2: wb_data = 2;
          default: wb_data = $urandom;
        endcase
        wb_we = ($urandom_range(0, 3) != 0);
        dump_addr = 5'($urandom);
        en = ($urandom_range(0, 99) != 0);
        @(negedge clk);
      end
      wb_we = 0;
      en = 1;
    end

    repeat (3) idle_cyc();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
